// File: rtl/gpio_board_io.sv
// gpio_board_io: debounced switches/keys into cpu_gpio_in, and cpu_gpio_out shown as 8 hex digits on a
// multiplexed active-low 7-segment display. Optional macro LEADING_ZERO_BLANK_EN hides leading zero digits.
module gpio_board_io #(
    parameter int SCAN_TICKS     = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter int DEBOUNCE_TICKS = 500000,
    parameter int NUM_SW         = 18
) (
    input  logic              clk,
    input  logic              res,
    input  logic [NUM_SW-1:0] sw,
    input  logic [3:0]        key_n,
    input  logic [31:0]       cpu_gpio_out,
    output logic [31:0]       cpu_gpio_in,
    output logic [6:0]        hex_seg_n,
    output logic [7:0]        hex_an_n
);
    localparam int NW     = NUM_SW + 4;
    localparam int TICK_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int SLOT_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEBOUNCE_TICKS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_TICKS - 1);
    localparam logic [SLOT_W-1:0] BLANK_N   = SLOT_W'(BLANK_CYCLES);

    typedef enum logic {BLANK, DRIVE} scanState_e;

    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [NW-1:0]     sync1_q, sync2_q, syncVal;
    logic [NW-1:0]     hist0_q, hist1_q, hist2_q, agree;
    logic [TICK_W-1:0] tickCnt_q, tickCnt_d;
    logic              tick;
    logic [31:0]       gpioIn_q, gpioIn_d;

    // Keys are stored as "pressed" after synchronization so history and output share one polarity.
    always_comb begin
        tick      = (tickCnt_q == TICK_LAST);
        tickCnt_d = tick ? '0 : tickCnt_q + TICK_W'(1);
        syncVal   = {~sync2_q[NW-1:NUM_SW], sync2_q[NUM_SW-1:0]};
        agree     = ~(hist0_q ^ hist1_q) & ~(hist1_q ^ hist2_q);
        gpioIn_d  = gpioIn_q;
        gpioIn_d[NW-1:0] = (agree & hist0_q) | (~agree & gpioIn_q[NW-1:0]);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            tickCnt_q <= '0;
            hist0_q   <= '0;
            hist1_q   <= '0;
            hist2_q   <= '0;
            gpioIn_q  <= '0;
        end else begin
            sync1_q   <= {key_n, sw};
            sync2_q   <= sync1_q;
            tickCnt_q <= tickCnt_d;
            if (tick) begin
                hist0_q <= syncVal;
                hist1_q <= hist0_q;
                hist2_q <= hist1_q;
            end
            gpioIn_q  <= gpioIn_d;
        end
    end

    assign cpu_gpio_in = gpioIn_q;

    scanState_e        state_q, state_d;
    logic [SLOT_W-1:0] slotCnt_q, slotCnt_d;
    logic [2:0]        digit_q, digit_d;
    logic [31:0]       snapshot_q, snapshot_d;
    logic [3:0]        nibble;
    logic              digitHidden;
    logic [6:0]        segN_d, hexSeg_q;
    logic [7:0]        anN_d, hexAn_q;

    // Outputs are computed from next-cycle scan position so they line up with the slot counter.
    always_comb begin
        slotCnt_d  = (slotCnt_q == SLOT_LAST) ? '0 : slotCnt_q + SLOT_W'(1);
        digit_d    = (slotCnt_q == SLOT_LAST) ? digit_q + 3'd1 : digit_q;
        state_d    = (slotCnt_d < BLANK_N) ? BLANK : DRIVE;
        snapshot_d = (state_q == BLANK && slotCnt_q == '0 && digit_q == 3'd0) ? cpu_gpio_out : snapshot_q;
        nibble     = snapshot_d[{digit_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        digitHidden = (digit_d != 3'd0) && ((snapshot_d >> {digit_d, 2'b00}) == 32'd0);
`else
        digitHidden = 1'b0;
`endif
        anN_d  = 8'hFF;
        segN_d = 7'h7F;
        if (state_d == DRIVE) begin
            anN_d  = ~(8'b1 << digit_d);
            segN_d = digitHidden ? 7'h7F : ~hexSeg(nibble);
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q    <= BLANK;
            slotCnt_q  <= '0;
            digit_q    <= 3'd0;
            snapshot_q <= '0;
            hexSeg_q   <= 7'h7F;
            hexAn_q    <= 8'hFF;
        end else begin
            state_q    <= state_d;
            slotCnt_q  <= slotCnt_d;
            digit_q    <= digit_d;
            snapshot_q <= snapshot_d;
            hexSeg_q   <= segN_d;
            hexAn_q    <= anN_d;
        end
    end

    assign hex_seg_n = hexSeg_q;
    assign hex_an_n  = hexAn_q;
endmodule

// File: tb/tb_gpio_board_io.sv
// Bench for gpio_board_io: random display values and switch/key patterns checked against an
// arithmetic model of the frame/slot schedule and of the debounce latency and glitch rules.
module tb_gpio_board_io;
    localparam int S      = 8;
    localparam int B      = 2;
    localparam int D      = 4;
    localparam int NSW    = 18;
    localparam int FRAME  = 8 * S;
    localparam int SETTLE = 2 + 3 * D + 1;

    logic            clk = 1'b0;
    logic            res = 1'b1;
    logic [NSW-1:0]  sw;
    logic [3:0]      key_n;
    logic [31:0]     cpu_gpio_out;
    logic [31:0]     cpu_gpio_in;
    logic [6:0]      hex_seg_n;
    logic [7:0]      hex_an_n;

    int          compared   = 0;
    int          mismatched = 0;
    int          cycleIdx   = 0;
    logic [31:0] snapModel  = 32'h0;
    logic [6:0]  segTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    gpio_board_io #(
        .SCAN_TICKS(S), .BLANK_CYCLES(B), .DEBOUNCE_TICKS(D), .NUM_SW(NSW)
    ) dut (
        .clk(clk), .res(res), .sw(sw), .key_n(key_n), .cpu_gpio_out(cpu_gpio_out),
        .cpu_gpio_in(cpu_gpio_in), .hex_seg_n(hex_seg_n), .hex_an_n(hex_an_n)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] gpioModel(input logic [NSW-1:0] swVal, input logic [3:0] keyVal);
        return {{(28 - NSW){1'b0}}, ~keyVal, swVal};
    endfunction

    function automatic logic [31:0] randVal();
        logic [31:0] v = $urandom;
        return v >> (4 * $urandom_range(0, 7));
    endfunction

    // Display model: cycle n after reset release sits in slot n%S of digit (n/S)%8,
    // showing the value cpu_gpio_out held at the first cycle of its frame.
    always @(negedge clk) begin
        int         slot;
        int         digit;
        logic [3:0] nib;
        logic [7:0] expAn;
        logic [6:0] expSeg;
        if (res) begin
            cycleIdx = 0;
            checkOutput("rstAn", {24'h0, hex_an_n}, 32'hFF);
            checkOutput("rstSeg", {25'h0, hex_seg_n}, 32'h7F);
            checkOutput("rstGpioIn", cpu_gpio_in, 32'h0);
        end else begin
            if (cycleIdx % FRAME == 0) snapModel = cpu_gpio_out;
            slot   = cycleIdx % S;
            digit  = (cycleIdx / S) % 8;
            expAn  = 8'hFF;
            expSeg = 7'h7F;
            if (slot >= B) begin
                nib    = 4'((snapModel >> (4 * digit)) & 32'hF);
                expAn  = ~(8'(1) << digit);
                expSeg = ~segTab[nib];
`ifdef LEADING_ZERO_BLANK_EN
                if (digit > 0 && (snapModel >> (4 * digit)) == 32'h0) expSeg = 7'h7F;
`endif
            end
            checkOutput("scanAn", {24'h0, hex_an_n}, {24'h0, expAn});
            checkOutput("scanSeg", {25'h0, hex_seg_n}, {25'h0, expSeg});
            checkOutput("gpioUpperZero", 32'(cpu_gpio_in[31:22]), 32'h0);
            cycleIdx++;
        end
    end

    task automatic applyStimulus(input logic [NSW-1:0] swVal, input logic [3:0] keyVal);
        @(posedge clk);
        #1;
        sw    = swVal;
        key_n = keyVal;
    endtask

    task automatic waitSlot(input int pos);
        for (int i = 0; i <= FRAME; i++) begin
            @(posedge clk);
            #1;
            if (cycleIdx % FRAME == pos) break;
        end
        checkOutput("slotAlign", 32'(cycleIdx % FRAME), 32'(pos));
    endtask

    task automatic waitGpio(input logic [31:0] exp, input string tag);
        for (int i = 0; i < SETTLE; i++) begin
            @(posedge clk);
            #1;
            if (cpu_gpio_in === exp) break;
        end
        checkOutput(tag, cpu_gpio_in, exp);
    endtask

    initial begin
        logic [NSW-1:0] curSw;
        logic [3:0]     curKey;
        logic [NSW-1:0] glitchSw;
        logic [3:0]     glitchKey;
        int             len;

        sw           = '0;
        key_n        = 4'hF;
        cpu_gpio_out = 32'h1234ABCD;
        res          = 1'b1;
        repeat (3) @(posedge clk);
        #1 res = 1'b0;

        // Frame 0 shows 1234ABCD; a change during digit 3 must not tear the frame.
        waitSlot(3 * S + 4);
        cpu_gpio_out = 32'h0;
        waitSlot(0);
        waitSlot(0);
        cpu_gpio_out = 32'h00000A05;
        waitSlot(0);
        cpu_gpio_out = 32'h0;
        waitSlot(0);
        for (int f = 0; f < 6; f++) begin
            cpu_gpio_out = randVal();
            waitSlot($urandom_range(1, FRAME - 1));
            cpu_gpio_out = randVal();
            waitSlot(0);
        end

        // Reset in the middle of a scan blanks at once and restarts at digit 0.
        repeat ($urandom_range(5, 60)) @(posedge clk);
        #1 res = 1'b1;
        #1;
        checkOutput("midRstAn", {24'h0, hex_an_n}, 32'hFF);
        checkOutput("midRstSeg", {25'h0, hex_seg_n}, 32'h7F);
        checkOutput("midRstGpioIn", cpu_gpio_in, 32'h0);
        repeat (2) @(posedge clk);
        #1 res = 1'b0;
        cpu_gpio_out = randVal();
        waitSlot(0);

        curSw  = '0;
        curKey = 4'hF;
        applyStimulus(curSw, curKey);
        waitGpio(gpioModel(curSw, curKey), "idleZero");
        curSw[5] = 1'b1;
        applyStimulus(curSw, curKey);
        waitGpio(gpioModel(curSw, curKey), "sw5Rise");

        glitchSw    = curSw;
        glitchSw[0] = 1'b1;
        applyStimulus(glitchSw, curKey);
        applyStimulus(curSw, curKey);
        for (int i = 0; i < 3 * D + 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("sw0Glitch", cpu_gpio_in, gpioModel(curSw, curKey));
        end

        curKey[2] = 1'b0;
        applyStimulus(curSw, curKey);
        waitGpio(gpioModel(curSw, curKey), "key2Press");

        for (int n = 0; n < 8; n++) begin
            curSw  = NSW'($urandom);
            curKey = 4'($urandom);
            applyStimulus(curSw, curKey);
            waitGpio(gpioModel(curSw, curKey), "randSettle");

            glitchSw  = curSw ^ NSW'($urandom);
            glitchKey = curKey ^ 4'($urandom);
            len       = $urandom_range(1, D - 1);
            for (int k = 0; k < len; k++) applyStimulus(glitchSw, glitchKey);
            applyStimulus(curSw, curKey);
            for (int i = 0; i < 3 * D + 4; i++) begin
                @(posedge clk);
                #1;
                checkOutput("randGlitch", cpu_gpio_in, gpioModel(curSw, curKey));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
